// File: rtl/ysyx_25040111_mtime_rdr.sv
// ysyx_25040111_mtime_rdr: reads the 64-bit mtime as two 32-bit words
// (hi, lo, hi) and retries torn samples a bounded number of times.
module ysyx_25040111_mtime_rdr #(
`ifdef RUNSOC
    parameter logic [31:0] BASE      = 32'h02000048,
`else
    parameter logic [31:0] BASE      = 32'ha0000048,
`endif
    parameter int          MAX_RETRY = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] MAX_R   = RW'(MAX_RETRY);
    localparam logic [31:0]   ADDR_HI = BASE + 32'd4;
    localparam logic [31:0]   ADDR_LO = BASE;

    typedef enum logic [2:0] {
        IDLE,
        AR_HI1,
        R_HI1,
        AR_LO,
        R_LO,
        AR_HI2,
        R_HI2,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [31:0]   hi1_q, hi1_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   araddr_q, araddr_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [63:0]   resp_data_q, resp_data_d;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign araddr     = araddr_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;

    // Next-state and registered-output computation for the hi/lo/hi sequence.
    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        hi1_d        = hi1_q;
        lo_d         = lo_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_data_d  = resp_data_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d    = AR_HI1;
                    retry_d    = '0;
                    resp_err_d = 1'b0;
                    araddr_d   = ADDR_HI;
                    arvalid_d  = 1'b1;
                end
            end
            AR_HI1: begin
                if (arready) begin
                    state_d   = R_HI1;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            R_HI1: begin
                if (rvalid) begin
                    state_d   = AR_LO;
                    hi1_d     = rdata;
                    rready_d  = 1'b0;
                    araddr_d  = ADDR_LO;
                    arvalid_d = 1'b1;
                end
            end
            AR_LO: begin
                if (arready) begin
                    state_d   = R_LO;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            R_LO: begin
                if (rvalid) begin
                    state_d   = AR_HI2;
                    lo_d      = rdata;
                    rready_d  = 1'b0;
                    araddr_d  = ADDR_HI;
                    arvalid_d = 1'b1;
                end
            end
            AR_HI2: begin
                if (arready) begin
                    state_d   = R_HI2;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            R_HI2: begin
                if (rvalid) begin
                    rready_d = 1'b0;
                    if (rdata == hi1_q) begin
                        state_d      = RESP;
                        resp_data_d  = {hi1_q, lo_q};
                        resp_valid_d = 1'b1;
                    end else if (retry_q < MAX_R) begin
                        // Hi word moved: re-read lo against the newer hi.
                        state_d   = AR_LO;
                        hi1_d     = rdata;
                        retry_d   = retry_q + RW'(1);
                        araddr_d  = ADDR_LO;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d      = RESP;
                        resp_data_d  = {rdata, 32'h0};
                        resp_err_d   = 1'b1;
                        resp_valid_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            retry_q      <= '0;
            hi1_q        <= '0;
            lo_q         <= '0;
            araddr_q     <= ADDR_HI;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            hi1_q        <= hi1_d;
            lo_q         <= lo_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_mtime_rdr.sv
// tb_ysyx_25040111_mtime_rdr: scripted timer responder plus a loop-based
// reference of the hi/lo/hi retry rule, with directed and random cases.
module tb_ysyx_25040111_mtime_rdr;

    localparam logic [31:0] BASE = 32'ha0000048;
    localparam logic [31:0] AHI  = BASE + 32'd4;
    localparam int          MAXR = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_data;
    logic        resp_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0;
    logic        rready;

    always #5 clock = ~clock;

    ysyx_25040111_mtime_rdr #(
        .BASE      (BASE),
        .MAX_RETRY (MAXR)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .rready     (rready)
    );

    int checks   = 0;
    int failures = 0;

    // Scripted values returned by successive hi and lo reads.
    logic [31:0] hq [8];
    logic [31:0] lq [8];
    int          hi_idx, lo_idx;
    int          ar_delay, r_delay, ar_cnt, r_cnt;
    bit          pend;
    logic [31:0] cur_addr;

    task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_clear();
        hi_idx = 0;
        lo_idx = 0;
        ar_cnt = 0;
        r_cnt  = 0;
        pend   = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b0;
    endtask

    // Responder: decides arready/rvalid for the coming cycle from live outputs.
    task automatic bus_step();
        int n;
        n = hi_idx + lo_idx;
        if (arvalid) begin
            if (!pend) begin
                pend     = 1'b1;
                cur_addr = araddr;
                check_eq("araddr_seq", araddr, (n % 2 == 0) ? AHI : BASE);
            end else begin
                check_eq("araddr_hold", araddr, cur_addr);
            end
            if (ar_cnt >= ar_delay) begin
                arready = 1'b1;
                ar_cnt  = 0;
            end else begin
                arready = 1'b0;
                ar_cnt++;
            end
        end else begin
            arready = 1'($urandom_range(0, 1));
        end
        if (rready) begin
            check_eq("r_addr_hold", araddr, cur_addr);
            check_eq("r_arvalid", arvalid, 0);
            if (r_cnt >= r_delay) begin
                rvalid = 1'b1;
                r_cnt  = 0;
                pend   = 1'b0;
                if (araddr == AHI) begin
                    rdata = hq[hi_idx & 7];
                    hi_idx++;
                end else begin
                    rdata = lq[lo_idx & 7];
                    lo_idx++;
                end
            end else begin
                rvalid = 1'b0;
                rdata  = $urandom;
                r_cnt++;
            end
        end else begin
            rvalid = 1'($urandom_range(0, 1));
            rdata  = $urandom;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        bus_step();
    endtask

    // Reference: walk the scripted reads applying the torn-read rule.
    function automatic void ref_model(output logic [63:0] d,
                                      output logic e, output int r);
        logic [31:0] h1;
        h1 = hq[0];
        r  = 0;
        d  = '0;
        e  = 1'b0;
        for (int k = 0; k <= MAXR; k++) begin
            if (hq[k+1] == h1) begin
                d = {h1, lq[k]};
                return;
            end
            if (r < MAXR) begin
                h1 = hq[k+1];
                r++;
            end else begin
                d = {hq[k+1], 32'h0};
                e = 1'b1;
                return;
            end
        end
    endfunction

    task automatic run_txn(string nm, int ad, int rd, int stall);
        logic [63:0] ed;
        logic        ee;
        int          er, lat, exp_lat, cnt;
        logic [63:0] held;
        bus_clear();
        ar_delay = ad;
        r_delay  = rd;
        ref_model(ed, ee, er);
        exp_lat = 7 + 4 * er + (ad + rd) * (3 + 2 * er);
        cnt = 0;
        while (!req_ready && cnt < 50) begin
            tick();
            cnt++;
        end
        check_eq({nm, "_idle"}, req_ready, 1);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        check_eq({nm, "_busy"}, req_ready, 0);
        while (!resp_valid && lat < 400) begin
            tick();
            lat++;
        end
        check_eq({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({nm, "_valid"}, resp_valid, 1);
        check_eq({nm, "_data"}, resp_data, ed);
        check_eq({nm, "_err"}, resp_err, ee);
        held = resp_data;
        for (int i = 0; i < stall; i++) begin
            tick();
            check_eq({nm, "_stall_valid"}, resp_valid, 1);
            check_eq({nm, "_stall_data"}, resp_data, held);
            check_eq({nm, "_stall_rdy"}, req_ready, 0);
            check_eq({nm, "_stall_bus"}, {arvalid, rready}, 0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_eq({nm, "_drop"}, resp_valid, 0);
        check_eq({nm, "_ret_idle"}, req_ready, 1);
        check_eq({nm, "_hi_reads"}, 64'(hi_idx), 64'(2 + er));
        check_eq({nm, "_lo_reads"}, 64'(lo_idx), 64'(1 + er));
    endtask

    task automatic mid_reset();
        int cnt;
        bus_clear();
        ar_delay = 0;
        r_delay  = 2;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        cnt = 0;
        while (!(rready && araddr == BASE) && cnt < 30) begin
            tick();
            cnt++;
        end
        check_eq("mr_in_rlo", {rready, araddr}, {1'b1, BASE});
        #2 reset = 1'b0;
        #1;
        check_eq("mr_arvalid", arvalid, 0);
        check_eq("mr_rready", rready, 0);
        check_eq("mr_resp_valid", resp_valid, 0);
        check_eq("mr_req_ready", req_ready, 1);
        check_eq("mr_araddr", araddr, AHI);
        bus_clear();
        @(negedge clock);
        reset = 1'b1;
        tick();
        check_eq("mr_after_rel", req_ready, 1);
    endtask

    initial begin
        logic [31:0] b;
        bus_clear();
        ar_delay = 0;
        r_delay  = 0;
        repeat (2) tick();
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_rready", rready, 0);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_err", resp_err, 0);
        check_eq("rst_resp_data", resp_data, 0);
        check_eq("rst_araddr", araddr, AHI);
        check_eq("rst_req_ready", req_ready, 1);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            hq[i] = 32'h1;
            lq[i] = 32'h0000_0100 + 32'(i);
        end
        run_txn("single", 0, 0, 0);

        hq[0] = 32'h0;
        hq[1] = 32'h1;
        hq[2] = 32'h1;
        lq[0] = 32'hffff_ffff;
        lq[1] = 32'h0000_0005;
        run_txn("rollover", 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            hq[i] = 32'h10 + 32'(i);
            lq[i] = 32'h500 + 32'(i);
        end
        run_txn("exhaust", 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            hq[i] = 32'h0000_0007;
            lq[i] = 32'h1234_0000 + 32'(i);
        end
        run_txn("backpr", 5, 3, 0);
        run_txn("stall", 0, 0, 10);

        mid_reset();
        run_txn("post_rst", 0, 0, 1);

        for (int t = 0; t < 25; t++) begin
            b = $urandom;
            hq[0] = b;
            for (int i = 1; i < 8; i++)
                hq[i] = ($urandom_range(0, 2) == 0) ? hq[i-1] + 32'd1 : hq[i-1];
            for (int i = 0; i < 8; i++)
                lq[i] = $urandom;
            run_txn("rand", $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_25040111_mtime_rdr.md
YSYX_25040111_MTIME_RDR -- requirements
Module: ysyx_25040111_mtime_rdr

Interface
REQ-001 SHALL have parameter BASE, default 32'ha0000048 (32'h02000048 under RUNSOC): mtime low-word address; high word at BASE+4.
REQ-002 SHALL have parameter MAX_RETRY, default 3: maximum number of torn-read retries before the result is flagged.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset; asserted when 0.
REQ-005 SHALL have port req_valid, input, 1: core requests one 64-bit mtime sample.
REQ-006 SHALL have port req_ready, output, 1: high only in IDLE.
REQ-007 SHALL have port resp_valid, output, 1: resp_data and resp_err are valid.
REQ-008 SHALL have port resp_ready, input, 1: core accepts the response.
REQ-009 SHALL have port resp_data, output, 64: mtime sample.
REQ-010 SHALL have port resp_err, output, 1: retry limit was exhausted.
REQ-011 SHALL have port araddr, output, 32: read address to the timer responder.
REQ-012 SHALL have port arvalid, output, 1: read address valid.
REQ-013 SHALL have port arready, input, 1: responder accepts the address.
REQ-014 SHALL have port rdata, input, 32: read data.
REQ-015 SHALL have port rvalid, input, 1: read data valid.
REQ-016 SHALL have port rready, output, 1: high in all R_* states.

Function
REQ-017 SHALL implement the FSM states IDLE, AR_HI1, R_HI1, AR_LO, R_LO, AR_HI2, R_HI2 and RESP.
REQ-018 SHALL, in IDLE, move to AR_HI1 on req_valid&req_ready, clear the retry counter and drop resp_err.
REQ-019 SHALL, in each AR_* state, hold arvalid=1 and move to the matching R_* state on arvalid&arready; if arready=0, SHALL hold the state and araddr.
REQ-020 SHALL, in each R_* state, hold arvalid=0 and rready=1, and capture rdata only on the rvalid&rready cycle.
REQ-021 SHALL drive araddr = BASE+4 in AR_HI1/R_HI1 and AR_HI2/R_HI2, and araddr = BASE in AR_LO/R_LO.
REQ-022 SHALL keep araddr stable from the AR_* cycle through the rvalid&rready cycle of the matching R_* state, because the responder decodes data from live araddr.
REQ-023 SHALL, on the R_HI1 handshake, store hi1 and move to AR_LO.
REQ-024 SHALL, on the R_LO handshake, store lo and move to AR_HI2.
REQ-025 SHALL, on the R_HI2 handshake with rdata==hi1, load resp_data={hi1,lo} and move to RESP.
REQ-026 SHALL, on the R_HI2 handshake with rdata!=hi1 and retry count < MAX_RETRY, set hi1<=rdata, increment the retry count and move to AR_LO.
REQ-027 SHALL, on the R_HI2 handshake with rdata!=hi1 and retry count == MAX_RETRY, load resp_data={rdata,32'h0}, set resp_err=1 and move to RESP.
REQ-028 SHALL, in RESP, hold resp_valid=1 with resp_data and resp_err stable until resp_ready, then return to IDLE; resp_valid SHALL drop the cycle after the handshake.
REQ-029 SHALL NOT accept a new request in the same cycle as the response handshake.
REQ-030 SHALL size the retry counter as clog2(MAX_RETRY+1) bits; it SHALL saturate and never wrap.
REQ-031 SHALL ignore rvalid outside R_* states and leave all stored registers unchanged in that case.
REQ-032 SHALL have a minimum latency, with arready=1 and rvalid one cycle after the address, of 7 cycles from the request handshake to resp_valid.
REQ-033 SHALL add 4 cycles of latency per retry.

Reset
REQ-034 SHALL, while reset=0, drive state=IDLE, arvalid=0, rready=0, resp_valid=0, resp_err=0, resp_data=0, araddr=BASE+4, retry count=0 and hi1=lo=0.
REQ-035 SHALL, on reset assertion mid-transaction, abandon the transaction immediately (asynchronously); no response is owed, and after release req_ready=1 on the first clock.

Verification
REQ-036 SHALL cover a single read: mtime=64'h0000_0001_0000_0100, ideal responder -> resp_valid 7 cycles after the request, resp_data=64'h0000_0001_0000_01xx, resp_err=0.
REQ-037 SHALL cover rollover: hi1=0, lo=32'hFFFF_FFFF, hi2=1 -> exactly one retry; final resp_data={32'h1,lo2}, resp_err=0, 11 cycles.
REQ-038 SHALL cover retry exhaustion: a model returning a different hi word on every hi read, MAX_RETRY=3 -> resp_err=1, resp_data[31:0]=0, resp_data[63:32]=last hi.
REQ-039 SHALL cover backpressure: arready low for 5 cycles and rvalid delayed 3 cycles -> araddr and arvalid stable throughout, correct data, no extra reads issued.
REQ-040 SHALL cover response stall: resp_ready low for 10 cycles -> resp_data stable, req_ready=0, no bus activity; return to IDLE the cycle after resp_ready.
REQ-041 SHALL cover mid-read reset: reset=0 during R_LO -> arvalid, rready and resp_valid go to 0 immediately; a subsequent request completes normally.
